// File: rtl/prescale_ctrl_if.sv
// Control/status bundle for prescale_ctrl.
// DIV_CLK_OUT_EN adds the divided square clock clk_out to the bundle.
interface prescale_ctrl_if #(
    parameter int unsigned CNT_W = 20
);
    logic             start;
    logic             stop;
    logic             oneshot;
    logic             div_wr;
    logic [CNT_W-1:0] div_val;
    logic             tick;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] count;
`ifdef DIV_CLK_OUT_EN
    logic             clk_out;
`endif

    // Controller side drives commands and observes status
    modport master (
        output start, stop, oneshot, div_wr, div_val,
        input  tick, done, busy, count
`ifdef DIV_CLK_OUT_EN
        , input clk_out
`endif
    );

    // Prescaler side
    modport slave (
        input  start, stop, oneshot, div_wr, div_val,
        output tick, done, busy, count
`ifdef DIV_CLK_OUT_EN
        , output clk_out
`endif
    );
endinterface

// File: rtl/prescale_ctrl.sv
// Programmable prescaler: emits a one-cycle tick every div+1 clk_in cycles,
// with one-shot/continuous modes, pause/resume and deferred divisor updates.
// Optional macro DIV_CLK_OUT_EN adds a divided square clock output.
module prescale_ctrl #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEFAULT_DIV = 65000
) (
    input  logic             clk_in,
    input  logic             rst,
    prescale_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_vld;
    logic             mode_os;
    logic             tick_q;
    logic             done_q;
    logic             busy_q;
    logic             terminal_c;
`ifdef DIV_CLK_OUT_EN
    logic             clk_out_q;
`endif

    // Last count of the current period
    assign terminal_c = (count_q == div_q);

    // Mode FSM, counter and divisor bookkeeping; stop has priority over start
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count_q   <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            pend_q    <= '0;
            pend_vld  <= 1'b0;
            mode_os   <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DIV_CLK_OUT_EN
            clk_out_q <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.div_wr) begin
                        div_q    <= bus.div_val;
                        pend_vld <= 1'b0;
                    end
                    if (bus.start && !bus.stop) begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        mode_os <= bus.oneshot;
                    end
                end
                RUN: begin
                    if (terminal_c) begin
                        tick_q  <= 1'b1;
                        done_q  <= mode_os;
                        count_q <= '0;
                        // A pending value becomes the new period; a write in
                        // this very cycle waits for the following terminal.
                        if (pend_vld) begin
                            div_q <= pend_q;
                        end
                        pend_vld <= bus.div_wr;
                        if (bus.div_wr) begin
                            pend_q <= bus.div_val;
                        end
`ifdef DIV_CLK_OUT_EN
                        clk_out_q <= ~clk_out_q;
`endif
                        if (bus.stop) begin
                            state <= HOLD;
                        end else if (mode_os) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
`ifdef DIV_CLK_OUT_EN
                            clk_out_q <= 1'b0;
`endif
                        end
                    end else begin
                        if (bus.div_wr) begin
                            pend_q   <= bus.div_val;
                            pend_vld <= 1'b1;
                        end
                        if (bus.stop) begin
                            state <= HOLD;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.div_wr) begin
                        pend_q   <= bus.div_val;
                        pend_vld <= 1'b1;
                    end
                    if (bus.stop) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
`ifdef DIV_CLK_OUT_EN
                        clk_out_q <= 1'b0;
`endif
                    end else if (bus.start) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
`ifdef DIV_CLK_OUT_EN
    assign bus.clk_out = clk_out_q;
`endif

endmodule

// File: tb/tb_prescale_ctrl.sv
// Self-checking bench for prescale_ctrl: cycle model plus directed scenarios.
module tb_prescale_ctrl;
    localparam int unsigned CNT_W = 20;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    prescale_ctrl_if #(.CNT_W(CNT_W)) bus ();

    prescale_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(65000)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    int tick_q[$];
    int done_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: position within the period, divisor, queued writes
    typedef enum {M_IDLE, M_RUN, M_HOLD} mphase_t;
    mphase_t m_ph   = M_IDLE;
    int      m_pos  = 0;
    int      m_div  = 65000;
    bit      m_os   = 1'b0;
    bit      m_tick = 1'b0;
    bit      m_done = 1'b0;
    bit      m_clk  = 1'b0;
    int      m_pq[$];

    always @(posedge clk_in) cyc++;

    always @(posedge clk_in or posedge rst) begin : model
        bit s, p, w, term;
        int wv;
        if (rst) begin
            m_ph = M_IDLE; m_pos = 0; m_div = 65000; m_os = 1'b0;
            m_tick = 1'b0; m_done = 1'b0; m_clk = 1'b0; m_pq.delete();
        end else begin
            s = bus.start; p = bus.stop; w = bus.div_wr; wv = int'(bus.div_val);
            m_tick = 1'b0; m_done = 1'b0;
            case (m_ph)
                M_IDLE: begin
                    if (w) begin m_div = wv; m_pq.delete(); end
                    if (s && !p) begin m_ph = M_RUN; m_pos = 0; m_os = bus.oneshot; end
                end
                M_RUN: begin
                    term = (m_pos == m_div);
                    if (term) begin
                        m_tick = 1'b1;
                        m_done = m_os;
                        m_pos  = 0;
                        m_clk  = !m_clk;
                        if (m_pq.size() > 0) begin m_div = m_pq[$]; m_pq.delete(); end
                        if (w) m_pq.push_back(wv);
                        if (p) m_ph = M_HOLD;
                        else if (m_os) begin m_ph = M_IDLE; m_clk = 1'b0; end
                    end else begin
                        if (w) m_pq.push_back(wv);
                        if (p) m_ph = M_HOLD;
                        else m_pos = m_pos + 1;
                    end
                end
                default: begin
                    if (w) m_pq.push_back(wv);
                    if (p) begin m_ph = M_IDLE; m_pos = 0; m_clk = 1'b0; end
                    else if (s) m_ph = M_RUN;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, and tick/done logging
    always @(negedge clk_in) begin
        if (chk_en) begin
            check("tick",  32'(bus.tick),  32'(m_tick));
            check("done",  32'(bus.done),  32'(m_done));
            check("busy",  32'(bus.busy),  32'(m_ph != M_IDLE));
            check("count", 32'(bus.count), 32'(m_pos));
`ifdef DIV_CLK_OUT_EN
            check("clk_out", 32'(bus.clk_out), 32'(m_clk));
`endif
            if (bus.tick === 1'b1) tick_q.push_back(cyc);
            if (bus.done === 1'b1) done_q.push_back(cyc);
        end
    end

    function automatic int tq(input int i);
        return (i < tick_q.size()) ? tick_q[i] : -1000;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start(input bit os, output int e0);
        bus.start = 1'b1; bus.oneshot = os;
        step(1);
        bus.start = 1'b0; bus.oneshot = 1'b0;
        e0 = cyc;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
    endtask

    task automatic set_div(input int v);
        bus.div_wr = 1'b1; bus.div_val = CNT_W'(v);
        step(1);
        bus.div_wr = 1'b0;
    endtask

    task automatic clear_logs();
        tick_q.delete(); done_q.delete();
    endtask

    initial begin
        int e0, er;
        bus.start = 1'b0; bus.stop = 1'b0; bus.oneshot = 1'b0;
        bus.div_wr = 1'b0; bus.div_val = '0;
        step(2);
        chk_en = 1'b1;
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_tick",  32'(bus.tick),  32'd0);
        rst = 1'b0;
        step(2);

        // Continuous, div=3
        set_div(3); clear_logs();
        pulse_start(1'b0, e0);
        step(13);
        check("c3_ntick",  32'(tick_q.size()), 32'd3);
        check("c3_first",  32'(tq(0) - e0), 32'd4);
        check("c3_gap",    32'(tq(1) - tq(0)), 32'd4);
        check("c3_busy",   32'(bus.busy), 32'd1);
        check("c3_ndone",  32'(done_q.size()), 32'd0);
        pulse_stop(); pulse_stop();

        // One-shot, div=5
        set_div(5); clear_logs();
        pulse_start(1'b1, e0);
        step(9);
        check("os5_ntick", 32'(tick_q.size()), 32'd1);
        check("os5_first", 32'(tq(0) - e0), 32'd6);
        check("os5_ndone", 32'(done_q.size()), 32'd1);
        check("os5_done_at", 32'((done_q.size() > 0 ? done_q[0] : -1000) - e0), 32'd6);
        check("os5_busy",  32'(bus.busy), 32'd0);

        // Pause at count 4, resume, abort, div=9
        set_div(9); clear_logs();
        pulse_start(1'b0, e0);
        step(4);
        pulse_stop();
        check("h9_frozen", 32'(bus.count), 32'd4);
        step(10);
        check("h9_held",   32'(bus.count), 32'd4);
        check("h9_notick", 32'(tick_q.size()), 32'd0);
        pulse_start(1'b0, er);
        step(7);
        check("h9_resume", 32'(tq(0) - er), 32'd6);
        pulse_stop(); pulse_stop();
        check("h9_abort_cnt",  32'(bus.count), 32'd0);
        check("h9_abort_busy", 32'(bus.busy),  32'd0);

        // Deferred divisor writes, last one wins, div=7
        set_div(7); clear_logs();
        pulse_start(1'b0, e0);
        step(3);
        bus.div_wr = 1'b1; bus.div_val = CNT_W'(2);
        step(1);
        bus.div_wr = 1'b0;
        step(1);
        bus.div_wr = 1'b1; bus.div_val = CNT_W'(1);
        step(1);
        bus.div_wr = 1'b0;
        step(7);
        check("dw_first", 32'(tq(0) - e0), 32'd8);
        check("dw_gap1",  32'(tq(1) - tq(0)), 32'd2);
        check("dw_gap2",  32'(tq(2) - tq(1)), 32'd2);
        pulse_stop(); pulse_stop();
        bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("ss_idle", 32'(bus.busy), 32'd0);

        // div=0 ticks every cycle; async reset mid-stream
        set_div(0); clear_logs();
        pulse_start(1'b0, e0);
        step(4);
        check("d0_ntick", 32'(tick_q.size()), 32'd3);
        check("d0_tick",  32'(bus.tick), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_tick",  32'(bus.tick),  32'd0);
        check("ar_count", 32'(bus.count), 32'd0);
        check("ar_busy",  32'(bus.busy),  32'd0);
        check("ar_done",  32'(bus.done),  32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        clear_logs();
        step(5);
        check("ar_notick", 32'(tick_q.size()), 32'd0);
        pulse_start(1'b0, e0);
        step(20);
        check("ar_defdiv", 32'(bus.count), 32'd20);
        pulse_stop(); pulse_stop();

`ifdef DIV_CLK_OUT_EN
        // Divided clock, div=1
        set_div(1);
        pulse_start(1'b0, e0);
        step(2);
        check("co_hi", 32'(bus.clk_out), 32'd1);
        step(2);
        check("co_lo", 32'(bus.clk_out), 32'd0);
        step(2);
        check("co_hi2", 32'(bus.clk_out), 32'd1);
        step(1);
        pulse_stop(); pulse_stop();
        check("co_idle", 32'(bus.clk_out), 32'd0);
`endif

        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prescale_ctrl.md
PRESCALE_CTRL -- requirements
Module: prescale_ctrl

Interface
REQ-001 Parameter CNT_W, default 20, sets the counter and divisor width in bits.
REQ-002 Parameter DEFAULT_DIV, default 65000, sets the divisor loaded at reset; SHALL be at most 2^CNT_W-1.
REQ-003 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  starts from IDLE or resumes from HOLD.
REQ-006 stop  input  1  pauses from RUN or aborts from HOLD.
REQ-007 oneshot  input  1  mode select, sampled only when start is accepted in IDLE: 1 = single period, 0 = continuous.
REQ-008 div_wr  input  1  divisor write strobe.
REQ-009 div_val  input  CNT_W  divisor value written on div_wr.
REQ-010 tick  output  1  registered one-cycle clock-enable pulse per elapsed period.
REQ-011 done  output  1  registered one-cycle pulse when a one-shot period completes.
REQ-012 busy  output  1  high when the state is not IDLE.
REQ-013 count  output  CNT_W  current counter value.
REQ-014 clk_out  output  1  divided square clock; present only when DIV_CLK_OUT_EN is defined.

Function
REQ-015 Period SHALL be div+1 clk_in cycles; the terminal condition is count==div; div=0 SHALL give a tick every cycle.
REQ-016 States: IDLE, RUN, HOLD, encoded in a registered state machine.
REQ-017 IDLE: start accepted means state goes to RUN, count goes to 0 and oneshot is latched; stop is ignored; count holds 0.
REQ-018 RUN, non-terminal cycle: count increments by 1.
REQ-019 RUN, terminal cycle: count goes to 0 and tick is high for the next cycle.
- Continuous mode: stays in RUN.
- One-shot mode: goes to IDLE, with done high in the same cycle as tick.
REQ-020 RUN with stop: goes to HOLD and count freezes; if that cycle is also terminal, tick and done are still issued and count is 0 in HOLD.
REQ-021 HOLD: start goes to RUN and counting resumes from the frozen count; stop goes to IDLE, count clears, and no tick or done is issued.
REQ-022 start and stop in the same cycle: stop SHALL win in every state.
REQ-023 Timing: start accepted at edge E0 means the first tick is high in the cycle after edge E0+div+1, and later ticks follow every div+1 cycles.
REQ-024 div_wr in IDLE: div takes div_val at the next edge.
REQ-025 div_wr in RUN or HOLD: the value goes to a pending register and is applied to div at the next terminal count; the period in progress is unaffected.
REQ-026 Multiple div_wr pulses before the pending value is applied: the last one wins.
REQ-027 div_wr in the same cycle as a terminal count: the written value takes effect from the following period.
REQ-028 Counter arithmetic is unsigned CNT_W bits; count SHALL never exceed div, so the counter never wraps at 2^CNT_W.

Reset
REQ-029 rst high SHALL immediately force the following values, regardless of clk_in: state IDLE, count 0, div DEFAULT_DIV, pending register empty, latched mode 0, tick 0, done 0, busy 0, clk_out 0.
REQ-030 rst asserted mid-period SHALL discard that period and any pending divisor; no tick or done is issued after release until a new start is accepted.
REQ-031 Release is synchronous to clk_in; the first start is accepted on the first rising edge with rst low.

Configuration
REQ-032 Macro DIV_CLK_OUT_EN.
- Defined: clk_out exists and toggles in the same cycle tick is high; it is forced to 0 on entry to IDLE; in HOLD it holds its value.
- Undefined: the clk_out port and its register are absent, and all other behaviour is identical.

Verification
REQ-033 div=3, oneshot=0, start pulse: tick pulses 4 cycles after the start edge, then every 4 cycles; busy=1; done stays 0.
REQ-034 div=5, oneshot=1, start: exactly one tick, with done in the same cycle 6 cycles after start; the block then returns to IDLE with busy=0.
REQ-035 div=9, continuous, stop at count=4, wait 10 cycles, start: count holds 4 in HOLD with no tick; the next tick arrives 6 cycles after resume; a second stop in HOLD gives IDLE with count=0.
REQ-036 div=7 running; div_wr with 2 at count=3, then with 1 at count=5: the current period ends at 7, then the period is 2 cycles (div=1); start and stop together cause no RUN entry.
REQ-037 div=0, continuous: tick is high every cycle; rst pulsed mid-stream gives tick=0, count=0, div=65000 and busy=0 immediately, without a clock edge.
REQ-038 With DIV_CLK_OUT_EN, div=1: clk_out toggles every 2 cycles; after stop then stop, clk_out=0.
